// File: rtl/project_mux_pkg.sv
// project_mux_pkg: shared definitions for the project IO multiplexer.
//   - Word offsets of the register window (low byte of the address).
//   - STATUS register bit positions.
//   - Switching FSM state encoding.
package project_mux_pkg;

    localparam logic [7:0] OFS_ACTIVE = 8'h00;
    localparam logic [7:0] OFS_STATUS = 8'h04;
    localparam logic [7:0] OFS_OEB_LO = 8'h08;
    localparam logic [7:0] OFS_OEB_HI = 8'h0C;

    localparam int ST_BUSY     = 0;
    localparam int ST_ERR      = 1;
    localparam int ST_DONE     = 2;
    localparam int ST_PEND_LSB = 8;
    localparam int ST_IRQ_EN   = 16;

    typedef enum logic {
        RUN     = 1'b0,
        QUIESCE = 1'b1
    } mux_state_e;

endpackage

// File: rtl/project_mux_regs.sv
// project_mux_regs: Wishbone slave for the project multiplexer.
//   Decodes the 256-byte window, generates a one-cycle ack per access,
//   stores the OEB mask and the sticky err/done flags, and serves reads.
//   Writes are captured with the access and applied at the end of the ack
//   cycle, so their effects are visible from the cycle after ack.
// Ports:
//   wb_clk_i / wb_rst_ni          clock, async active-low reset
//   wbs_*                         Wishbone slave interface
//   busy, active, pending         FSM status for readback
//   done_set                      pulse from the FSM when a switch completes
//   act_wr/act_target/act_force   ACTIVE write strobe (one cycle) to the FSM
//   oeb_mask                      software output-enable mask
//   irq_o                         registered done & irq_enable (MUX_IRQ_EN only)
// Optional feature macro: MUX_IRQ_EN.
module project_mux_regs
    import project_mux_pkg::*;
#(
    parameter int          NUM_PROJECTS = 8,
    parameter int          IO_PADS      = 38,
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_ni,
    input  logic               wbs_stb_i,
    input  logic               wbs_cyc_i,
    input  logic               wbs_we_i,
    input  logic [3:0]         wbs_sel_i,
    input  logic [31:0]        wbs_adr_i,
    input  logic [31:0]        wbs_dat_i,
    output logic               wbs_ack_o,
    output logic [31:0]        wbs_dat_o,
    input  logic               busy,
    input  logic [7:0]         active,
    input  logic [7:0]         pending,
    input  logic               done_set,
    output logic               act_wr,
    output logic [7:0]         act_target,
    output logic               act_force,
    output logic [IO_PADS-1:0] oeb_mask
`ifdef MUX_IRQ_EN
    ,
    output logic               irq_o
`endif
);

    logic               ack_reg;
    logic [31:0]        dat_reg;
    logic               wr_reg;
    logic [5:0]         wofs_reg;
    logic [31:0]        wdat_reg;
    logic [3:0]         wsel_reg;
    logic [IO_PADS-1:0] mask_reg;
    logic [IO_PADS-1:0] mask_next;
    logic               err_reg;
    logic               done_reg;
    logic               irq_en_bit;

    logic               access;
    logic [5:0]         ofs;
    logic [31:0]        rdata;
    logic [63:0]        mask_ext;
    logic               wr_status;
    logic               err_set;
    logic               err_clr;
    logic               done_clr;
    logic               unused_adr;

    // The ack-high gate stops a master that holds stb through the ack edge
    // from being served twice.
    assign access     = wbs_cyc_i & wbs_stb_i & ~ack_reg
                      & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign ofs        = wbs_adr_i[7:2];
    assign unused_adr = ^wbs_adr_i[1:0];

    assign wbs_ack_o = ack_reg;
    assign wbs_dat_o = dat_reg;
    assign oeb_mask  = mask_reg;
    assign mask_ext  = 64'(mask_reg);

    always_comb begin
        rdata = '0;
        case ({ofs, 2'b00})
            OFS_ACTIVE: rdata[7:0] = active;
            OFS_STATUS: begin
                rdata[ST_BUSY]            = busy;
                rdata[ST_ERR]             = err_reg;
                rdata[ST_DONE]            = done_reg;
                rdata[ST_PEND_LSB +: 8]   = pending;
                rdata[ST_IRQ_EN]          = irq_en_bit;
            end
            OFS_OEB_LO: rdata = mask_ext[31:0];
            OFS_OEB_HI: rdata = mask_ext[63:32];
            default:    rdata = '0;
        endcase
    end

    // ACTIVE needs byte 0; the force bit lives in byte 1.
    assign act_wr     = wr_reg & (wofs_reg == OFS_ACTIVE[7:2]) & wsel_reg[0];
    assign act_target = wdat_reg[7:0];
    assign act_force  = wdat_reg[8] & wsel_reg[1];

    assign wr_status = wr_reg & (wofs_reg == OFS_STATUS[7:2]);
    assign err_set   = act_wr & ({24'd0, act_target} >= 32'(NUM_PROJECTS));
    assign err_clr   = wr_status & wsel_reg[0] & wdat_reg[ST_ERR];
    assign done_clr  = wr_status & wsel_reg[0] & wdat_reg[ST_DONE];

    // Per-bit mask update: each pad bit belongs to one word and one byte lane.
    genvar gi;
    generate
        for (gi = 0; gi < IO_PADS; gi++) begin : g_mask
            localparam int          BIT  = gi % 32;
            localparam int          LANE = BIT / 8;
            localparam logic [5:0]  WOFS = (gi < 32) ? OFS_OEB_LO[7:2] : OFS_OEB_HI[7:2];
            assign mask_next[gi] = (wr_reg && (wofs_reg == WOFS) && wsel_reg[LANE])
                                 ? wdat_reg[BIT] : mask_reg[gi];
        end
    endgenerate

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack_reg  <= 1'b0;
            dat_reg  <= '0;
            wr_reg   <= 1'b0;
            wofs_reg <= '0;
            wdat_reg <= '0;
            wsel_reg <= '0;
            mask_reg <= '1;
            err_reg  <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            ack_reg  <= access;
            wr_reg   <= access & wbs_we_i;
            if (access) begin
                wofs_reg <= ofs;
                wdat_reg <= wbs_dat_i;
                wsel_reg <= wbs_sel_i;
                if (!wbs_we_i) begin
                    dat_reg <= rdata;
                end
            end
            mask_reg <= mask_next;
            if (err_set) begin
                err_reg <= 1'b1;
            end else if (err_clr) begin
                err_reg <= 1'b0;
            end
            // A completing switch beats a simultaneous clear.
            if (done_set) begin
                done_reg <= 1'b1;
            end else if (done_clr) begin
                done_reg <= 1'b0;
            end
        end
    end

`ifdef MUX_IRQ_EN
    logic irq_en_reg;
    logic irq_reg;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            irq_en_reg <= 1'b0;
            irq_reg    <= 1'b0;
        end else begin
            if (wr_status && wsel_reg[2]) begin
                irq_en_reg <= wdat_reg[ST_IRQ_EN];
            end
            irq_reg <= done_reg & irq_en_reg;
        end
    end

    assign irq_en_bit = irq_en_reg;
    assign irq_o      = irq_reg;
`else
    assign irq_en_bit = 1'b0;
`endif

endmodule

// File: rtl/project_mux_ctrl.sv
// project_mux_ctrl: Wishbone-controlled multiplexer of NUM_PROJECTS user
// projects onto a shared IO_PADS-wide pad bus with safe switching.
//   A switch parks all projects (pads hi-z, outputs 0, all projects in
//   reset) for SETTLE_CYCLES cycles before the new project gets the pads.
// Ports:
//   wb_clk_i / wb_rst_ni   clock, async active-low reset
//   wbs_*                  Wishbone slave (see project_mux_regs)
//   io_in/io_out/io_oeb    pad side; io_oeb active-low
//   proj_io_in/proj_io_out flattened per-project buses, slice k at k*IO_PADS
//   proj_rst_o             per-project active-high reset
//   irq_o                  completion interrupt (MUX_IRQ_EN only)
// Optional feature macro: MUX_IRQ_EN.
module project_mux_ctrl
    import project_mux_pkg::*;
#(
    parameter int          NUM_PROJECTS  = 8,
    parameter int          IO_PADS       = 38,
    parameter logic [31:0] BASE_ADDR     = 32'h3000_0000,
    parameter int          SETTLE_CYCLES = 16
) (
    input  logic                            wb_clk_i,
    input  logic                            wb_rst_ni,
    input  logic                            wbs_stb_i,
    input  logic                            wbs_cyc_i,
    input  logic                            wbs_we_i,
    input  logic [3:0]                      wbs_sel_i,
    input  logic [31:0]                     wbs_adr_i,
    input  logic [31:0]                     wbs_dat_i,
    output logic                            wbs_ack_o,
    output logic [31:0]                     wbs_dat_o,
    input  logic [IO_PADS-1:0]              io_in,
    output logic [IO_PADS-1:0]              io_out,
    output logic [IO_PADS-1:0]              io_oeb,
    output logic [NUM_PROJECTS*IO_PADS-1:0] proj_io_in,
    input  logic [NUM_PROJECTS*IO_PADS-1:0] proj_io_out,
    output logic [NUM_PROJECTS-1:0]         proj_rst_o
`ifdef MUX_IRQ_EN
    ,
    output logic                            irq_o
`endif
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int IDX_W = (NUM_PROJECTS > 1) ? $clog2(NUM_PROJECTS) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    mux_state_e         state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [7:0]         active_reg, active_next;
    logic [7:0]         pending_reg, pending_next;
    logic               done_set;
    logic               target_ok;
    logic               run;

    logic               act_wr;
    logic [7:0]         act_target;
    logic               act_force;
    logic [IO_PADS-1:0] oeb_mask;
    logic [IDX_W-1:0]   active_idx;
    logic [IO_PADS-1:0] proj_out_arr [NUM_PROJECTS];
    logic [NUM_PROJECTS-1:0] proj_sel;

    project_mux_regs #(
        .NUM_PROJECTS (NUM_PROJECTS),
        .IO_PADS      (IO_PADS),
        .BASE_ADDR    (BASE_ADDR)
    ) u_regs (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_ni  (wb_rst_ni),
        .wbs_stb_i  (wbs_stb_i),
        .wbs_cyc_i  (wbs_cyc_i),
        .wbs_we_i   (wbs_we_i),
        .wbs_sel_i  (wbs_sel_i),
        .wbs_adr_i  (wbs_adr_i),
        .wbs_dat_i  (wbs_dat_i),
        .wbs_ack_o  (wbs_ack_o),
        .wbs_dat_o  (wbs_dat_o),
        .busy       (state_reg == QUIESCE),
        .active     (active_reg),
        .pending    (pending_reg),
        .done_set   (done_set),
        .act_wr     (act_wr),
        .act_target (act_target),
        .act_force  (act_force),
        .oeb_mask   (oeb_mask)
`ifdef MUX_IRQ_EN
        ,
        .irq_o      (irq_o)
`endif
    );

    assign target_ok = ({24'd0, act_target} < 32'(NUM_PROJECTS));

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        active_next  = active_reg;
        pending_next = pending_reg;
        done_set     = 1'b0;
        case (state_reg)
            RUN: begin
                if (act_wr && target_ok && ((act_target != active_reg) || act_force)) begin
                    pending_next = act_target;
                    cnt_next     = CNT_LOAD;
                    state_next   = QUIESCE;
                end
            end
            QUIESCE: begin
                // Retargeting restarts the full settle window; it takes
                // priority over completion in the same cycle.
                if (act_wr && target_ok) begin
                    pending_next = act_target;
                    cnt_next     = CNT_LOAD;
                end else if (cnt_reg == '0) begin
                    active_next = pending_reg;
                    done_set    = 1'b1;
                    state_next  = RUN;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_reg   <= RUN;
            cnt_reg     <= '0;
            active_reg  <= '0;
            pending_reg <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            active_reg  <= active_next;
            pending_reg <= pending_next;
        end
    end

    // Pad and project muxing is purely combinational from the state
    // registers, so an asynchronous reset reaches the pads without a clock.
    assign run        = (state_reg == RUN);
    assign active_idx = active_reg[IDX_W-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PROJECTS; gi++) begin : g_proj
            assign proj_out_arr[gi] = proj_io_out[gi*IO_PADS +: IO_PADS];
            assign proj_sel[gi]     = run && (active_reg == 8'(gi));
            assign proj_rst_o[gi]   = ~proj_sel[gi];
            assign proj_io_in[gi*IO_PADS +: IO_PADS] = proj_sel[gi] ? io_in : '0;
        end
    endgenerate

    assign io_out = run ? proj_out_arr[active_idx] : '0;
    assign io_oeb = run ? oeb_mask : '1;

endmodule
